// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, limits and decimal-to-packed-BCD conversion
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  function automatic logic [63:0] to_bcd(input int unsigned v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one decimal digit of a rippled BCD increment/decrement
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  input  logic       en,
  output bcd_digit_t nxt,
  output logic       co
);
  logic wrap;
  assign wrap = up ? (digit == BCD_MAX_DIGIT) : (digit == 4'd0);
  assign co   = en & wrap;
  assign nxt  = !en ? digit : wrap ? (up ? 4'd0 : BCD_MAX_DIGIT) : up ? digit + 4'd1 : digit - 4'd1;
endmodule

// File: rtl/bcd_occupancy_counter.sv
// bcd_occupancy_counter: saturating BCD up/down occupancy counter
// Optional capacity limit and full flag via OCCUPANCY_CAPACITY_EN.
module bcd_occupancy_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int CAPACITY = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  input  logic                dec,
  output logic [4*DIGITS-1:0] count,
  output logic                upd,
  output logic                ovf,
  output logic                unf,
`ifdef OCCUPANCY_CAPACITY_EN
  output logic                full,
`endif
  output logic                empty
);
  localparam int W = 4 * DIGITS;
  localparam logic [63:0] MAX_FULL = to_bcd(10 ** DIGITS - 1);
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];
  logic [W-1:0] nxt;
  logic [DIGITS:0] c;
  logic inc_blk;
  assign c[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_step u_step (
      .digit(count[4*g+:4]),
      .up   (inc),
      .en   (c[g]),
      .nxt  (nxt[4*g+:4]),
      .co   (c[g+1])
    );
  end
  assign empty = (count == '0);
`ifdef OCCUPANCY_CAPACITY_EN
  localparam logic [63:0] CAP_FULL = to_bcd(CAPACITY);
  localparam logic [W-1:0] CAP_BCD = CAP_FULL[W-1:0];
  assign full    = (count >= CAP_BCD);
  assign inc_blk = (count == MAX_BCD) | full;
`else
  assign inc_blk = (count == MAX_BCD);
`endif
  // a borrow out of the top digit while counting down means count was zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      upd   <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      upd <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      if (clr) begin
        count <= '0;
        upd   <= |count;
      end else if (inc && !dec) begin
        if (inc_blk) ovf <= 1'b1;
        else begin
          count <= nxt;
          upd   <= 1'b1;
        end
      end else if (dec && !inc) begin
        if (c[DIGITS]) unf <= 1'b1;
        else begin
          count <= nxt;
          upd   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_occupancy_counter.sv
// tb_bcd_occupancy_counter: directed self-checking bench for the BCD occupancy counter
module tb_bcd_occupancy_counter;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [7:0] count;
  logic upd, ovf, unf, empty;
`ifdef OCCUPANCY_CAPACITY_EN
  logic full;
`endif
  int checks = 0, errors = 0;

  bcd_occupancy_counter #(.DIGITS(2), .CAPACITY(50)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (inc),
    .dec  (dec),
    .count(count),
    .upd  (upd),
    .ovf  (ovf),
    .unf  (unf),
`ifdef OCCUPANCY_CAPACITY_EN
    .full (full),
`endif
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input logic i, input logic d, input logic c);
    @(negedge clk);
    inc = i; dec = d; clr = c;
    @(posedge clk);
    #1;
    inc = 1'b0; dec = 1'b0; clr = 1'b0;
  endtask

  task automatic flags(input string tag, input logic [7:0] cnt, input logic u, input logic o, input logic n);
    chk({tag, "_count"}, {24'd0, count}, {24'd0, cnt});
    chk({tag, "_upd"}, {31'd0, upd}, {31'd0, u});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, o});
    chk({tag, "_unf"}, {31'd0, unf}, {31'd0, n});
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    flags("reset", 8'h00, 0, 0, 0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    for (int k = 0; k < 37; k++) step(1, 0, 0);
    flags("up37", 8'h37, 1, 0, 0);
    chk("up37_empty", {31'd0, empty}, 32'd0);
    @(negedge clk); inc = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", {24'd0, count}, 32'h00);
    chk("async_empty", {31'd0, empty}, 32'd1);
    @(negedge clk); inc = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    flags("post_rst", 8'h00, 0, 0, 0);
    for (int k = 0; k < 9; k++) step(1, 0, 0);
    flags("up09", 8'h09, 1, 0, 0);
    step(1, 0, 0);
    flags("ripple10", 8'h10, 1, 0, 0);
    for (int k = 0; k < 88; k++) step(1, 0, 0);
    flags("up98", 8'h98, 1, 0, 0);
    step(1, 0, 0);
    flags("b2b_99", 8'h99, 1, 0, 0);
    step(1, 0, 0);
    flags("b2b_ovf1", 8'h99, 0, 1, 0);
    step(1, 0, 0);
    flags("b2b_ovf2", 8'h99, 0, 1, 0);
    step(0, 0, 0);
    flags("idle99", 8'h99, 0, 0, 0);
    step(0, 0, 1);
    flags("clr99", 8'h00, 1, 0, 0);
    step(0, 0, 1);
    flags("clr00", 8'h00, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(1, 0, 0);
    step(0, 1, 0);
    flags("ripdn09", 8'h09, 1, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 1, 0);
    flags("dn00", 8'h00, 1, 0, 0);
    step(0, 1, 0);
    flags("unf", 8'h00, 0, 0, 1);
    chk("unf_empty", {31'd0, empty}, 32'd1);
    step(0, 0, 0);
    flags("idle00", 8'h00, 0, 0, 0);
    for (int k = 0; k < 42; k++) step(1, 0, 0);
    flags("up42", 8'h42, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 0);
    flags("both42", 8'h42, 0, 0, 0);
    step(1, 1, 1);
    flags("allclr", 8'h00, 1, 0, 0);
`ifdef OCCUPANCY_CAPACITY_EN
    for (int k = 0; k < 49; k++) step(1, 0, 0);
    flags("cap49", 8'h49, 1, 0, 0);
    chk("cap49_full", {31'd0, full}, 32'd0);
    step(1, 0, 0);
    flags("cap50", 8'h50, 1, 0, 0);
    chk("cap50_full", {31'd0, full}, 32'd1);
    step(1, 0, 0);
    flags("cap_ovf", 8'h50, 0, 1, 0);
    step(0, 1, 0);
    flags("cap_dn", 8'h49, 1, 0, 0);
    chk("cap_dn_full", {31'd0, full}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
